// File: rtl/spi_master_ctrl.sv
// SPI master: one DATA_W-bit word per start, MSB first, configurable CPOL/CPHA.
// Every output comes straight from a flop whose next value is derived from the next FSM state.
module spi_master_ctrl #(
    parameter int CPOL    = 1,
    parameter int CPHA    = 1,
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);
    typedef enum logic [1:0] {IDLE, ASSERT, XFER, HOLD} state_t;

    localparam int            EW        = $clog2(2*DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W);
    localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
    localparam logic [7:0]    TICK_VAL  = 8'(CLK_DIV - 1);
    localparam logic          SCLK_IDLE = (CPOL != 0);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d, edge_nxt;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d, cs_n_q, cs_n_d, busy_q, busy_d;
    logic              done_q, done_d, mosi_q, mosi_d;
    logic              tick, leading;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        tick      = (cnt_q == TICK_VAL);
        edge_nxt  = edge_q + EDGE_ONE;
        leading   = edge_nxt[0];

        // Every tick either changes state or starts a new half-period, so clearing
        // on tick also covers the clear-on-state-entry rule.
        if (state_q != IDLE) cnt_d = tick ? 8'd0 : cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                sclk_d = SCLK_IDLE;
                cnt_d  = 8'd0;
                edge_d = '0;
                if (start) begin
                    tx_d    = tx_data;
                    rx_d    = '0;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (CPHA == 0) begin
                        if (leading) rx_d = {rx_q[DATA_W-2:0], miso};
                        else if (edge_nxt != LAST_EDGE) tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end else begin
                        if (!leading) rx_d = {rx_q[DATA_W-2:0], miso};
                        else if (edge_nxt != EDGE_ONE) tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (edge_nxt == LAST_EDGE) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = IDLE;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = (state_d == IDLE);
        busy_d = !cs_n_d;
        mosi_d = cs_n_d ? 1'b0 : tx_d[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= SCLK_IDLE;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mosi_q    <= mosi_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Four SPI masters (one per CPOL/CPHA mode) each driven against a mode-matched slave model.
// The slave and bus monitor work from observed sclk edges only.
module tb_spi_master_ctrl;
    localparam int NI = 4;
    localparam logic [NI-1:0] CPOL_V = 4'b1001;
    localparam logic [NI-1:0] CPHA_V = 4'b0101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_s [NI];
    logic [7:0] tx_s    [NI];
    logic [7:0] rx_s    [NI];
    logic       sclk_s  [NI];
    logic       cs_s    [NI];
    logic       mosi_s  [NI];
    logic       miso_s  [NI];
    logic       busy_s  [NI];
    logic       done_s  [NI];

    // Slave word and loopback select, set by the test per transfer
    logic [7:0] swd [NI];
    logic       lb  [NI];
    // Monitor state
    int         tog [NI], bcnt [NI], dcnt [NI], run [NI], gap [NI];
    logic [7:0] cap [NI];
    logic       psclk [NI], pcs [NI];

    int checks = 0;
    int errors = 0;

    function automatic int div_of(int i);
        case (i)
            0: return 4;
            1: return 2;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int DIV = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 2;
        spi_master_ctrl #(
            .CPOL(CPOL_V[g] ? 1 : 0), .CPHA(CPHA_V[g] ? 1 : 0), .CLK_DIV(DIV), .DATA_W(8)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start_s[g]), .tx_data(tx_s[g]),
            .rx_data(rx_s[g]), .busy(busy_s[g]), .done(done_s[g]), .cs_n(cs_s[g]),
            .sclk(sclk_s[g]), .mosi(mosi_s[g]), .miso(miso_s[g])
        );
    end

    // Slave presents bit k = number of completed bit periods, changing on its launch edge
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < NI; i++) begin
            if (CPHA_V[i]) k = (tog[i] == 0) ? 0 : (tog[i] - 1) / 2;
            else           k = tog[i] / 2;
            if (k > 7) k = 7;
            miso_s[i] = lb[i] ? mosi_s[i] : swd[i][7-k];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            psclk[i] <= sclk_s[i];
            pcs[i]   <= cs_s[i];
            if (done_s[i]) dcnt[i] <= dcnt[i] + 1;
            if (!cs_s[i] && pcs[i]) bcnt[i] <= 1;
            else if (busy_s[i]) bcnt[i] <= bcnt[i] + 1;
            if (cs_s[i]) run[i] <= run[i] + 1;
            else if (pcs[i]) begin
                gap[i] <= run[i];
                run[i] <= 0;
                tog[i] <= 0;
                cap[i] <= 8'h00;
            end else if (sclk_s[i] != psclk[i]) begin
                tog[i] <= tog[i] + 1;
                // slave samples on leading edges for CPHA=0, trailing for CPHA=1
                if ((((tog[i] + 1) % 2) == 1) != CPHA_V[i]) cap[i] <= {cap[i][6:0], mosi_s[i]};
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done_s[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("done_seen[%0d]", i), int'(ok), 1);
    endtask

    task automatic wait_tog(input int i, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (tog[i] >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("tog_reached[%0d]", i), int'(ok), 1);
    endtask

    task automatic run_xfer(input int i, input logic [7:0] tx, input logic [7:0] sw,
                            input logic l, input logic [7:0] exp_rx, input int exp_busy,
                            input string nm);
        int d0;
        bit ok;
        logic [7:0] old_rx;
        swd[i] = sw;
        lb[i]  = l;
        @(negedge clk);
        tx_s[i] = tx;
        start_s[i] = 1'b1;
        d0 = dcnt[i];
        old_rx = rx_s[i];
        @(negedge clk);
        start_s[i] = 1'b0;
        tx_s[i] = 8'($urandom);
        chk({nm, "_assert_cs"}, int'(cs_s[i]), 0);
        chk({nm, "_assert_busy"}, int'(busy_s[i]), 1);
        chk({nm, "_assert_mosi"}, int'(mosi_s[i]), int'(tx[7]));
        chk({nm, "_assert_sclk"}, int'(sclk_s[i]), int'(CPOL_V[i]));
        chk({nm, "_rx_hold"}, int'(rx_s[i]), int'(old_rx));
        wait_done(i, ok);
        if (ok) begin
            chk({nm, "_rx"}, int'(rx_s[i]), int'(exp_rx));
            chk({nm, "_mosi_word"}, int'(cap[i]), int'(tx));
            chk({nm, "_toggles"}, tog[i], 16);
            chk({nm, "_busy_cycles"}, bcnt[i], exp_busy);
            chk({nm, "_idle_cs"}, int'(cs_s[i]), 1);
            chk({nm, "_idle_sclk"}, int'(sclk_s[i]), int'(CPOL_V[i]));
            chk({nm, "_idle_mosi"}, int'(mosi_s[i]), 0);
        end
        @(negedge clk);
        chk({nm, "_done_width"}, int'(done_s[i]), 0);
        chk({nm, "_done_count"}, dcnt[i], d0 + 1);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] tx;
        logic [7:0] sw;
        logic       lb;
        logic [7:0] exp_rx;
        int         exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        int d0;
        vecs[0] = '{0, 8'hA5, 8'h00, 1'b1, 8'hA5, 72};
        vecs[1] = '{1, 8'h3C, 8'hC3, 1'b0, 8'hC3, 36};
        vecs[2] = '{0, 8'h81, 8'h6C, 1'b0, 8'h6C, 72};
        vecs[3] = '{1, 8'h81, 8'h6C, 1'b0, 8'h6C, 36};
        vecs[4] = '{2, 8'h81, 8'h6C, 1'b0, 8'h6C, 54};
        vecs[5] = '{3, 8'h81, 8'h6C, 1'b0, 8'h6C, 36};

        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0; tx_s[i] = 8'h00; swd[i] = 8'h00; lb[i] = 1'b0;
            tog[i] = 0; bcnt[i] = 0; dcnt[i] = 0; run[i] = 0; gap[i] = 0;
            cap[i] = 8'h00; pcs[i] = 1'b1; psclk[i] = CPOL_V[i];
        end

        // Reset state, with start asserted throughout to confirm it is ignored
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) start_s[i] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_sclk[%0d]", i), int'(sclk_s[i]), int'(CPOL_V[i]));
            chk($sformatf("rst_cs[%0d]", i), int'(cs_s[i]), 1);
            chk($sformatf("rst_mosi[%0d]", i), int'(mosi_s[i]), 0);
            chk($sformatf("rst_busy[%0d]", i), int'(busy_s[i]), 0);
            chk($sformatf("rst_done[%0d]", i), int'(done_s[i]), 0);
            chk($sformatf("rst_rx[%0d]", i), int'(rx_s[i]), 0);
            start_s[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Abort by reset around the 5th sclk toggle
        swd[0] = 8'h00; lb[0] = 1'b1;
        tx_s[0] = 8'hA5; start_s[0] = 1'b1;
        d0 = dcnt[0];
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_tog(0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cs", int'(cs_s[0]), 1);
        chk("abort_sclk", int'(sclk_s[0]), int'(CPOL_V[0]));
        chk("abort_busy", int'(busy_s[0]), 0);
        chk("abort_done", int'(done_s[0]), 0);
        chk("abort_rx", int'(rx_s[0]), 0);
        repeat (100) @(negedge clk);
        chk("abort_no_done", dcnt[0], d0);
        chk("abort_rx_later", int'(rx_s[0]), 0);
        chk("abort_busy_later", int'(busy_s[0]), 0);

        // Directed vectors
        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].inst, vecs[v].tx, vecs[v].sw, vecs[v].lb,
                     vecs[v].exp_rx, vecs[v].exp_busy, $sformatf("vec%0d", v));

        // start during XFER is ignored
        swd[0] = 8'h3D; lb[0] = 1'b0;
        @(negedge clk);
        tx_s[0] = 8'h5A; start_s[0] = 1'b1;
        d0 = dcnt[0];
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_tog(0, 3);
        tx_s[0] = 8'hFF; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, ok);
        chk("ign_rx", int'(rx_s[0]), 8'h3D);
        chk("ign_mosi_word", int'(cap[0]), 8'h5A);
        repeat (20) @(negedge clk);
        chk("ign_done_count", dcnt[0], d0 + 1);
        chk("ign_not_queued", int'(busy_s[0]), 0);

        // start held high: back-to-back words
        swd[1] = 8'h5E; lb[1] = 1'b0;
        @(negedge clk);
        tx_s[1] = 8'h12; start_s[1] = 1'b1;
        d0 = dcnt[1];
        wait_done(1, ok);
        chk("b2b_rx1", int'(rx_s[1]), 8'h5E);
        chk("b2b_mosi1", int'(cap[1]), 8'h12);
        swd[1] = 8'hA7; tx_s[1] = 8'h34;
        @(negedge clk);
        chk("b2b_restart_busy", int'(busy_s[1]), 1);
        chk("b2b_restart_cs", int'(cs_s[1]), 0);
        start_s[1] = 1'b0;
        wait_done(1, ok);
        chk("b2b_rx2", int'(rx_s[1]), 8'hA7);
        chk("b2b_mosi2", int'(cap[1]), 8'h34);
        chk("b2b_cs_gap", gap[1], 1);
        @(negedge clk);
        chk("b2b_done_count", dcnt[1], d0 + 2);

        // Randomised transfers against the reference expectations
        for (int r = 0; r < 24; r++) begin
            int         i;
            logic [7:0] t, s;
            logic       l;
            i = int'($urandom_range(0, NI - 1));
            t = 8'($urandom);
            s = 8'($urandom);
            l = 1'($urandom);
            run_xfer(i, t, s, l, l ? t : s, (2*8 + 2) * div_of(i), $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
